// File: rtl/spi_slave_ram_if.sv
// ---------------------------------------------------------------------------
// spi_slave_ram_if
//   Word-level link between the SPI slave shifter and the command RAM.
//
//   din      [9:0]  command (din[9:8]) and address/data payload (din[7:0])
//   rx_valid        din is valid this cycle
//   dout     [7:0]  read data handed back to the shifter for MISO
//   tx_valid        dout carries fresh read data (one-cycle pulse)
//
//   master : the SPI slave shifter side (drives din/rx_valid)
//   slave  : the RAM side (drives dout/tx_valid)
// ---------------------------------------------------------------------------
interface spi_slave_ram_if;
  logic [9:0] din;
  logic       rx_valid;
  logic [7:0] dout;
  logic       tx_valid;

  modport master (
    output din,
    output rx_valid,
    input  dout,
    input  tx_valid
  );

  modport slave (
    input  din,
    input  rx_valid,
    output dout,
    output tx_valid
  );
endinterface

// File: rtl/spi_slave_ram.sv
// ---------------------------------------------------------------------------
// spi_slave_ram
//   Single-port synchronous RAM driven by 10-bit command words from an SPI
//   slave. Each accepted word (rx_valid = 1) is one of:
//     00 : load read address   (rd_addr <= payload)
//     01 : read data           (dout <= MEM[rd_addr], tx_valid pulses)
//     10 : load write address  (wr_addr <= payload)
//     11 : write data          (MEM[wr_addr] <= payload)
//   Commands take effect on the rising edge that samples them.
//
// Ports
//   clk  : system clock, all state changes on its rising edge
//   rst  : asynchronous active-high reset (clears dout, tx_valid, addresses;
//          the memory array keeps its contents)
//   bus  : spi_slave_ram_if.slave (din, rx_valid in; dout, tx_valid out)
//
// Parameters
//   MEM_DEPTH : number of 8-bit words in MEM
//   ADDR_SIZE : address register width (low ADDR_SIZE bits of din[7:0])
//
// Build option
//   SPI_RAM_ADDR_AUTOINC_EN : when defined, rd_addr advances after every
//   executed read-data command and wr_addr after every executed write-data
//   command, wrapping from MEM_DEPTH-1 to 0, so bursts need one address word.
//   Undefined (default): addresses change only on address commands or reset.
// ---------------------------------------------------------------------------
module spi_slave_ram #(
  parameter int MEM_DEPTH = 256,
  parameter int ADDR_SIZE = 8
) (
  input  logic             clk,
  input  logic             rst,
  spi_slave_ram_if.slave   bus
);

  localparam logic [1:0] CMD_RD_ADDR = 2'b00;
  localparam logic [1:0] CMD_RD_DATA = 2'b01;
  localparam logic [1:0] CMD_WR_ADDR = 2'b10;
  localparam logic [1:0] CMD_WR_DATA = 2'b11;

  logic [7:0]           MEM [0:MEM_DEPTH-1];

  logic [ADDR_SIZE-1:0] rd_addr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [7:0]           dout_p0;
  logic                 vld_p0;

  logic [1:0]           cmd;
  logic [7:0]           payload;
  logic [ADDR_SIZE-1:0] addr_payload;
  logic                 wr_en;

  assign cmd          = bus.din[9:8];
  assign payload      = bus.din[7:0];
  assign addr_payload = bus.din[ADDR_SIZE-1:0];

  // Address decodes beyond MEM_DEPTH only exist when the array is smaller
  // than the address space; those accesses are dropped (write) or read as 0.
  function automatic logic addr_in_range(input logic [ADDR_SIZE-1:0] a);
    return (int'(a) < MEM_DEPTH);
  endfunction

  // Burst advance with wrap at the top of the populated array rather than at
  // the top of the address space.
  function automatic logic [ADDR_SIZE-1:0] addr_next(input logic [ADDR_SIZE-1:0] a);
    if (int'(a) >= MEM_DEPTH - 1)
      return '0;
    else
      return a + 1'b1;
  endfunction

  // Writes are suppressed while rst is high so an aborted sequence cannot
  // land in the array.
  assign wr_en = !rst && bus.rx_valid && (cmd == CMD_WR_DATA) && addr_in_range(wr_addr);

  // Stage p0: command execution -- memory write port
  always_ff @(posedge clk) begin
    if (wr_en)
      MEM[wr_addr] <= payload;
  end

  // Stage p0: command execution -- address registers, read data, strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_addr <= '0;
      wr_addr <= '0;
      dout_p0 <= '0;
      vld_p0  <= 1'b0;
    end else begin
      vld_p0 <= 1'b0;
      if (bus.rx_valid) begin
        case (cmd)
          CMD_RD_ADDR: rd_addr <= addr_payload;
          CMD_RD_DATA: begin
            dout_p0 <= addr_in_range(rd_addr) ? MEM[rd_addr] : 8'h00;
            vld_p0  <= 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            rd_addr <= addr_next(rd_addr);
`endif
          end
          CMD_WR_ADDR: wr_addr <= addr_payload;
          CMD_WR_DATA: begin
`ifdef SPI_RAM_ADDR_AUTOINC_EN
            wr_addr <= addr_next(wr_addr);
`endif
          end
          default: ;
        endcase
      end
    end
  end

`ifndef SPI_RAM_ADDR_AUTOINC_EN
  // addr_next is only used by the burst build.
  logic [ADDR_SIZE-1:0] unused_next;
  assign unused_next = addr_next(rd_addr);
`endif

  assign bus.dout     = dout_p0;
  assign bus.tx_valid = vld_p0;

endmodule

// File: tb/tb_spi_slave_ram.sv
// ---------------------------------------------------------------------------
// tb_spi_slave_ram
//   Randomized bench for spi_slave_ram with a transaction-level reference
//   model (array + address variables updated per accepted command word).
// ---------------------------------------------------------------------------
module tb_spi_slave_ram;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_ram_if bus ();

  spi_slave_ram #(
    .MEM_DEPTH(256),
    .ADDR_SIZE(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] mem_m [0:255];
  logic [7:0] rd_m;
  logic [7:0] wr_m;
  logic [7:0] dout_m;
  logic       tx_m;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%02h expected 0x%02h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    rd_m   = 8'h00;
    wr_m   = 8'h00;
    dout_m = 8'h00;
    tx_m   = 1'b0;
  endtask

  // One accepted (or ignored) command word at a clock edge.
  task automatic model_step(input logic [1:0] c, input logic [7:0] p, input logic rv);
    tx_m = 1'b0;
    if (rv) begin
      case (c)
        2'b00: rd_m = p;
        2'b01: begin
          dout_m = mem_m[rd_m];
          tx_m   = 1'b1;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          rd_m = rd_m + 8'd1;
`endif
        end
        2'b10: wr_m = p;
        default: begin
          mem_m[wr_m] = p;
`ifdef SPI_RAM_ADDR_AUTOINC_EN
          wr_m = wr_m + 8'd1;
`endif
        end
      endcase
    end
  endtask

  task automatic send(input logic [1:0] c, input logic [7:0] p, input logic rv, input string tag);
    @(negedge clk);
    bus.din      = {c, p};
    bus.rx_valid = rv;
    @(posedge clk);
    model_step(c, p, rv);
    #1;
    check({tag, ".dout"}, bus.dout, dout_m);
    check({tag, ".txv"}, 8'(bus.tx_valid), 8'(tx_m));
  endtask

  initial begin
    logic [7:0] a, d, held, prev;

    rst          = 1'b1;
    bus.din      = '0;
    bus.rx_valid = 1'b0;
    model_reset();

    // Reset held with random read commands, rx_valid low
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      bus.din      = {($urandom_range(0, 1) == 1) ? 2'b01 : 2'b00, 8'($urandom)};
      bus.rx_valid = 1'b0;
      @(posedge clk);
      #1;
      check("rst_hold.dout", bus.dout, 8'h00);
      check("rst_hold.txv", 8'(bus.tx_valid), 8'h00);
    end

    // Preload MEM[i] = i
    @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      dut.MEM[i] = 8'(i);
      mem_m[i]   = 8'(i);
    end
    rst = 1'b0;

    // Walk all addresses: read-address then read-data
    for (int i = 0; i < 256; i++) begin
      send(2'b00, 8'(i), 1'b1, "walk_addr");
      send(2'b01, 8'($urandom), 1'b1, "walk_data");
      check("walk_val", bus.dout, 8'(i));
    end

    // Directed write/read
    send(2'b10, 8'h3C, 1'b1, "wr3c_waddr");
    send(2'b11, 8'hA5, 1'b1, "wr3c_wdata");
    send(2'b00, 8'h3C, 1'b1, "wr3c_raddr");
    send(2'b01, 8'h00, 1'b1, "wr3c_rdata");
    check("wr3c_val", bus.dout, 8'hA5);
    check("wr3c_txv", 8'(bus.tx_valid), 8'h01);

    // Random write/read pairs
    for (int i = 0; i < 25; i++) begin
      a = 8'($urandom);
      d = 8'($urandom);
      send(2'b10, a, 1'b1, "wrr_waddr");
      send(2'b11, d, 1'b1, "wrr_wdata");
      send(2'b00, a, 1'b1, "wrr_raddr");
      send(2'b01, 8'($urandom), 1'b1, "wrr_rdata");
      check("wrr_val", bus.dout, d);
    end

    // Same sequence with rx_valid low: nothing may change
    for (int i = 0; i < 10; i++) begin
      a    = 8'($urandom);
      d    = 8'($urandom);
      held = dout_m;
      prev = mem_m[a];
      send(2'b10, a, 1'b0, "idle_waddr");
      send(2'b11, d, 1'b0, "idle_wdata");
      send(2'b00, a, 1'b0, "idle_raddr");
      send(2'b01, 8'h00, 1'b0, "idle_rdata");
      check("idle_hold", bus.dout, held);
      send(2'b00, a, 1'b1, "idle_chk_raddr");
      send(2'b01, 8'h00, 1'b1, "idle_chk_rdata");
      check("idle_mem", bus.dout, prev);
    end

    // Reset in the middle of a read sequence
    send(2'b00, 8'h10, 1'b1, "mid_raddr");
    send(2'b01, 8'h00, 1'b1, "mid_rdata_pre");
    @(negedge clk);
    rst          = 1'b1;
    bus.din      = {2'b11, 8'h77};
    bus.rx_valid = 1'b1;
    #1;
    model_reset();
    check("mid_rst_async.dout", bus.dout, 8'h00);
    check("mid_rst_async.txv", 8'(bus.tx_valid), 8'h00);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("mid_rst.dout", bus.dout, 8'h00);
      check("mid_rst.txv", 8'(bus.tx_valid), 8'h00);
    end
    @(negedge clk);
    rst          = 1'b0;
    bus.rx_valid = 1'b0;
    send(2'b01, 8'h00, 1'b1, "mid_rdata_post");
    check("mid_post_val", bus.dout, mem_m[0]);

    // Burst sequence across the top address
    send(2'b10, 8'hFF, 1'b1, "bst_waddr");
    send(2'b11, 8'h11, 1'b1, "bst_wd0");
    send(2'b11, 8'h22, 1'b1, "bst_wd1");
    send(2'b00, 8'hFF, 1'b1, "bst_raddr");
    send(2'b01, 8'h00, 1'b1, "bst_rd0");
`ifdef SPI_RAM_ADDR_AUTOINC_EN
    check("bst_rd0_val", bus.dout, 8'h11);
`else
    check("bst_rd0_val", bus.dout, 8'h22);
`endif
    send(2'b01, 8'h00, 1'b1, "bst_rd1");
    check("bst_rd1_val", bus.dout, 8'h22);
    check("bst_rd1_txv", 8'(bus.tx_valid), 8'h01);

    // Random mixed traffic
    for (int i = 0; i < 400; i++) begin
      send(2'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0), "rand");
    end

    // Final array comparison
    @(negedge clk);
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 256; i++) begin
      check("mem_final", dut.MEM[i], mem_m[i]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
